// File: rtl/button_debouncer.sv
// Push-button debouncer: accepts a level change only after STABLE_CNT identical
// consecutive samples, then emits a one-cycle edge pulse and counts presses.
module button_debouncer #(
  parameter int unsigned STABLE_CNT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  output logic       level,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here is updated with <= so all reads in this block see
  // the pre-edge values; blocking assignments would make the order of statements matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE_LOW;
      cnt         <= '0;
      level       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      press_count <= 8'd0;
    end else begin
      // Pulses are single-cycle: cleared unless an acceptance below sets them.
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;

      case (state)
        IDLE_LOW: begin
          if (sig_in) begin
            state <= CHECK_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end

        CHECK_HIGH: begin
          if (!sig_in) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE_HIGH;
            cnt         <= '0;
            level       <= 1'b1;
            rise_pulse  <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IDLE_HIGH: begin
          if (!sig_in) begin
            state <= CHECK_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end

        CHECK_LOW: begin
          if (sig_in) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            level      <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule
